serial_subtractor: RTL and testbench

SERIAL_SUBTRACTOR -- requirements
Module: serial_subtractor

---
 rtl/serial_subtractor_if.sv | 26 ++
 rtl/serial_subtractor.sv | 93 +++++++++
 tb/tb_serial_subtractor.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/serial_subtractor_if.sv
// Operand/result bundle for the bit-serial subtractor.
// The master drives the request and operands; the slave returns status, result and flags.
interface serial_subtractor_if #(
  parameter int unsigned N_BITS = 8
);
  logic              start;
  logic [N_BITS-1:0] A;
  logic [N_BITS-1:0] B;
  logic              busy;
  logic              done;
  logic [N_BITS-1:0] S;
  logic              N;
  logic              Z;
  logic              P;
  logic              V;

  modport master (
    output start, A, B,
    input  busy, done, S, N, Z, P, V
  );

  modport slave (
    input  start, A, B,
    output busy, done, S, N, Z, P, V
  );
endinterface

// File: rtl/serial_subtractor.sv
// Bit-serial two's-complement subtractor: S = A - B computed LSB first as A + ~B + 1,
// one full-adder step per cycle, with N/Z/P/V flags loaded alongside the result.
module serial_subtractor #(
  parameter int unsigned N_BITS = 8
) (
  input logic                 clk,
  input logic                 reset,
  serial_subtractor_if.slave  bus
);

  localparam int unsigned CntW = (N_BITS > 1) ? $clog2(N_BITS) : 1;
  localparam logic [CntW-1:0] LastBit = CntW'(N_BITS - 1);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e            state_q;
  logic [N_BITS-1:0] a_q, b_q, work_q, s_q;
  logic [CntW-1:0]   cnt_q;
  logic              carry_q, busy_q, done_q;
  logic              n_q, z_q, p_q, v_q;

  logic              fa_a, fa_b, fa_sum, fa_cout;
  logic [N_BITS-1:0] result;

  // Single full-adder cell; the subtrahend bit is inverted and carry starts at 1.
  always_comb begin
    fa_a    = a_q[cnt_q];
    fa_b    = ~b_q[cnt_q];
    fa_sum  = fa_a ^ fa_b ^ carry_q;
    fa_cout = (fa_a & fa_b) | (carry_q & (fa_a ^ fa_b));
    result  = {fa_sum, work_q[N_BITS-1:1]};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      a_q     <= '0;
      b_q     <= '0;
      work_q  <= '0;
      s_q     <= '0;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      n_q     <= 1'b0;
      z_q     <= 1'b1;
      p_q     <= 1'b1;
      v_q     <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (bus.start) begin
            a_q     <= bus.A;
            b_q     <= bus.B;
            cnt_q   <= '0;
            carry_q <= 1'b1;
            busy_q  <= 1'b1;
            state_q <= StRun;
          end
        end
        StRun: begin
          carry_q <= fa_cout;
          work_q  <= result;
          cnt_q   <= cnt_q + CntW'(1);
          if (cnt_q == LastBit) begin
            s_q     <= result;
            n_q     <= result[N_BITS-1];
            z_q     <= (result == '0);
            p_q     <= ~result[0];
            v_q     <= (a_q[N_BITS-1] != b_q[N_BITS-1]) && (result[N_BITS-1] != a_q[N_BITS-1]);
            done_q  <= 1'b1;
            state_q <= StDone;
          end
        end
        StDone: begin
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.S    = s_q;
  assign bus.N    = n_q;
  assign bus.Z    = z_q;
  assign bus.P    = p_q;
  assign bus.V    = v_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed and random checks of serial_subtractor against an arithmetic model of A - B.
module tb_serial_subtractor;

  localparam int unsigned W = 8;

  logic clk = 1'b0;
  logic reset;

  int vectors = 0;
  int miscompares = 0;

  serial_subtractor_if #(.N_BITS(W)) bus ();

  serial_subtractor #(.N_BITS(W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_flags(input string tag, input logic [7:0] s, input logic n, input logic z,
                             input logic p, input logic v);
    check({tag, ".S"}, 32'(bus.S), 32'(s));
    check({tag, ".N"}, 32'(bus.N), 32'(n));
    check({tag, ".Z"}, 32'(bus.Z), 32'(z));
    check({tag, ".P"}, 32'(bus.P), 32'(p));
    check({tag, ".V"}, 32'(bus.V), 32'(v));
  endtask

  // Reference: plain signed arithmetic, overflow judged from the exact difference.
  task automatic model(input logic [7:0] a, input logic [7:0] b, output logic [7:0] s,
                       output logic n, output logic z, output logic p, output logic v);
    int diff;
    diff = int'($signed(a)) - int'($signed(b));
    s    = 8'(diff);
    n    = (diff < 0) ? (diff >= -128) : (diff > 127);
    n    = s[7];
    z    = (s == 8'd0);
    p    = ~s[0];
    v    = (diff > 127) || (diff < -128);
  endtask

  // Issue one operation and track it cycle by cycle; optionally re-raise start with
  // other operands while the operation is running and through its done cycle.
  task automatic run_op(input string tag, input logic [7:0] a, input logic [7:0] b,
                        input bit collide);
    logic [7:0] es;
    logic en, ez, ep, ev;
    int pulses;
    model(a, b, es, en, ez, ep, ev);
    pulses = 0;
    bus.start = 1'b1;
    bus.A = a;
    bus.B = b;
    tick();
    bus.start = 1'b0;
    for (int i = 1; i <= int'(W); i++) begin
      if (collide && i == 3) begin
        bus.start = 1'b1;
        bus.A = ~a;
        bus.B = a;
      end
      tick();
      if (bus.done === 1'b1) pulses++;
      if (i < int'(W)) check({tag, ".busy_run"}, 32'(bus.busy), 32'd1);
    end
    bus.start = 1'b0;
    check({tag, ".done"}, 32'(bus.done), 32'd1);
    check({tag, ".busy_done"}, 32'(bus.busy), 32'd1);
    check_flags(tag, es, en, ez, ep, ev);
    tick();
    if (bus.done === 1'b1) pulses++;
    check({tag, ".idle_busy"}, 32'(bus.busy), 32'd0);
    check({tag, ".pulses"}, 32'(pulses), 32'd1);
    check({tag, ".S_hold"}, 32'(bus.S), 32'(es));
  endtask

  initial begin
    logic [7:0] ra, rb;
    bus.start = 1'b1;
    bus.A = 8'd9;
    bus.B = 8'd4;
    reset = 1'b1;
    tick();
    tick();
    check("rst.busy", 32'(bus.busy), 32'd0);
    check("rst.done", 32'(bus.done), 32'd0);
    check_flags("rst", 8'd0, 1'b0, 1'b1, 1'b1, 1'b0);

    // Start held through reset is taken on the first edge after reset drops.
    reset = 1'b0;
    tick();
    check("start_after_rst.busy", 32'(bus.busy), 32'd1);
    bus.start = 1'b0;
    for (int i = 0; i < int'(W) + 1; i++) tick();
    check("start_after_rst.S", 32'(bus.S), 32'd5);

    // Back-to-back operations exercise the N_BITS+2 throughput.
    run_op("sub5_3", 8'd5, 8'd3, 1'b0);
    run_op("sub3_5", 8'd3, 8'd5, 1'b0);
    run_op("min_1", 8'h80, 8'd1, 1'b0);
    run_op("max_m1", 8'h7f, 8'hff, 1'b0);
    run_op("sub7_7", 8'd7, 8'd7, 1'b0);
    run_op("collide", 8'd100, 8'd37, 1'b1);
    tick();
    check("collide.idle_done", 32'(bus.done), 32'd0);
    check("collide.idle_busy", 32'(bus.busy), 32'd0);

    // Abort on bit 4: reset sampled on the edge that would compute bit 4.
    bus.start = 1'b1;
    bus.A = 8'd50;
    bus.B = 8'd20;
    tick();
    bus.start = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("abort.busy", 32'(bus.busy), 32'd0);
    check("abort.done", 32'(bus.done), 32'd0);
    check("abort.S", 32'(bus.S), 32'd0);
    check("abort.Z", 32'(bus.Z), 32'd1);
    for (int i = 0; i < int'(W); i++) begin
      tick();
      check("abort.no_done", 32'(bus.done), 32'd0);
    end
    run_op("after_abort", 8'd50, 8'd20, 1'b0);

    for (int k = 0; k < 20; k++) begin
      ra = 8'($urandom);
      rb = 8'($urandom);
      run_op($sformatf("rand%0d", k), ra, rb, k[2]);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
